// File: rtl/grf_scoreboard.sv
// Issue-stage hazard scoreboard for the register file: tracks in-flight writes per register
// and stalls decode when a source is not yet forwardable or a register's write counter is full.
module grf_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int CW   = 3,
    parameter int PW   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_valid,
    input  logic            iss_we,
    input  logic [AW-1:0]   iss_waddr,
    input  logic [CW-1:0]   iss_tnew,
    input  logic [AW-1:0]   iss_rs,
    input  logic [CW-1:0]   iss_rs_tuse,
    input  logic [AW-1:0]   iss_rt,
    input  logic [CW-1:0]   iss_rt_tuse,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_addr,
    output logic            stall,
    output logic            issue,
    output logic [NREG-1:0] busy_vec
);

    logic [PW-1:0]   pending     [NREG];
    logic [CW-1:0]   cnt         [NREG];
    logic [PW-1:0]   eff_pending [NREG];
    logic [PW-1:0]   pend_nxt    [NREG];
    logic [CW-1:0]   cnt_nxt     [NREG];
    logic [NREG-1:0] inc_v;
    logic [NREG-1:0] dec_v;
    logic            hz_rs;
    logic            hz_rt;
    logic            hz_w;

    // A write retiring this cycle is already visible to same-cycle source reads.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            eff_pending[i] = pending[i];
            if (dec_v[i])
                eff_pending[i] = pending[i] - PW'(1);
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int i = 1; i < NREG; i++)
            busy_vec[i] = (eff_pending[i] != '0);
    end

    assign hz_rs = (iss_rs != '0) && (eff_pending[iss_rs] != '0) && (cnt[iss_rs] > iss_rs_tuse);
    assign hz_rt = (iss_rt != '0) && (eff_pending[iss_rt] != '0) && (cnt[iss_rt] > iss_rt_tuse);
    assign hz_w  = iss_we && (iss_waddr != '0) && (pending[iss_waddr] == '1);

    assign stall = iss_valid && !flush && (hz_rs || hz_rt || hz_w);
    assign issue = iss_valid && !flush && !stall;

    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int i = 1; i < NREG; i++) begin
            inc_v[i] = issue && iss_we && (iss_waddr == AW'(i));
            dec_v[i] = wb_we && (wb_addr == AW'(i)) && (pending[i] != '0);
        end
    end

    // Youngest writer owns the countdown; it saturates at zero and clears once nothing is pending.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            pend_nxt[i] = pending[i] + PW'(inc_v[i]) - PW'(dec_v[i]);
            if (pend_nxt[i] == '0)
                cnt_nxt[i] = '0;
            else if (inc_v[i])
                cnt_nxt[i] = iss_tnew;
            else if (cnt[i] != '0)
                cnt_nxt[i] = cnt[i] - CW'(1);
            else
                cnt_nxt[i] = cnt[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                pending[i] <= '0;
                cnt[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                pending[i] <= pend_nxt[i];
                cnt[i]     <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_grf_scoreboard.sv
// Randomised and directed bench for grf_scoreboard against an absolute-time model of
// in-flight writes (count per register plus the cycle the youngest becomes forwardable).
module tb_grf_scoreboard;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int CW   = 3;
    localparam int PW   = 2;
    localparam int MAXP = 3;

    logic            clk;
    logic            rst;
    logic            iss_valid;
    logic            iss_we;
    logic [AW-1:0]   iss_waddr;
    logic [CW-1:0]   iss_tnew;
    logic [AW-1:0]   iss_rs;
    logic [CW-1:0]   iss_rs_tuse;
    logic [AW-1:0]   iss_rt;
    logic [CW-1:0]   iss_rt_tuse;
    logic            flush;
    logic            wb_we;
    logic [AW-1:0]   wb_addr;
    logic            stall;
    logic            issue;
    logic [NREG-1:0] busy_vec;

    int checks = 0;
    int passed = 0;
    int pend  [NREG];
    int ready [NREG];
    int cyc = 0;

    grf_scoreboard #(.NREG(NREG), .AW(AW), .CW(CW), .PW(PW)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_we(iss_we), .iss_waddr(iss_waddr), .iss_tnew(iss_tnew),
        .iss_rs(iss_rs), .iss_rs_tuse(iss_rs_tuse), .iss_rt(iss_rt), .iss_rt_tuse(iss_rt_tuse),
        .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr),
        .stall(stall), .issue(issue), .busy_vec(busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int mcnt(int r);
        if (pend[r] == 0) return 0;
        return (ready[r] > cyc) ? ready[r] - cyc : 0;
    endfunction

    function automatic int meff(int r);
        if (r != 0 && wb_we && int'(wb_addr) == r && pend[r] > 0) return pend[r] - 1;
        return pend[r];
    endfunction

    function automatic bit mhz(int a, int tuse);
        return (a != 0) && (meff(a) > 0) && (mcnt(a) > tuse);
    endfunction

    // Returns {stall, issue, busy_vec} expected for the current inputs and model state.
    function automatic logic [NREG+1:0] mexp();
        logic            s;
        logic            iss;
        logic [NREG-1:0] b;
        bit              hw;
        hw  = iss_we && (iss_waddr != 0) && (pend[int'(iss_waddr)] == MAXP);
        s   = iss_valid && !flush && (mhz(int'(iss_rs), int'(iss_rs_tuse)) ||
                                      mhz(int'(iss_rt), int'(iss_rt_tuse)) || hw);
        iss = iss_valid && !flush && !s;
        b   = '0;
        for (int i = 1; i < NREG; i++) b[i] = (meff(i) > 0);
        return {s, iss, b};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NREG; i++) begin
            pend[i]  = 0;
            ready[i] = 0;
        end
    endtask

    task automatic advance();
        logic [NREG+1:0] e;
        int w;
        int a;
        e = mexp();
        w = int'(iss_waddr);
        a = int'(wb_addr);
        @(posedge clk);
        if (!rst) begin
            if (wb_we && a != 0 && pend[a] > 0) pend[a]--;
            if (e[NREG] && iss_we && w != 0) begin
                pend[w]++;
                ready[w] = cyc + 1 + int'(iss_tnew);
            end
        end
        cyc++;
        #1;
    endtask

    task automatic set_idle();
        iss_valid = 0; iss_we = 0; iss_waddr = '0; iss_tnew = '0;
        iss_rs = '0; iss_rs_tuse = '0; iss_rt = '0; iss_rt_tuse = '0;
        flush = 0; wb_we = 0; wb_addr = '0;
    endtask

    task automatic set_iss(int v, int we, int wa, int tnew, int rs, int rsu, int rt, int rtu);
        iss_valid = v[0]; iss_we = we[0]; iss_waddr = AW'(wa); iss_tnew = CW'(tnew);
        iss_rs = AW'(rs); iss_rs_tuse = CW'(rsu); iss_rt = AW'(rt); iss_rt_tuse = CW'(rtu);
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1;
        model_clear();
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [NREG+1:0] e;
        rst = 1;
        model_clear();
        for (int k = 0; k < 4; k++) begin
            set_iss(1, 1, $urandom_range(1, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                    0, $urandom_range(0, 7), 0);
            flush = k[0];
            wb_we = 1; wb_addr = AW'($urandom_range(0, 7));
            e = mexp();
            @(negedge clk);
            checks++;
            if ({stall, issue, busy_vec} !== {1'b0, iss_valid & ~flush, {NREG{1'b0}}} ||
                {stall, issue, busy_vec} !== e)
                $display("[TB] FAIL reset%0d: got stall=%b issue=%b busy=%h want stall=0 issue=%b busy=0",
                         k, stall, issue, busy_vec, iss_valid & ~flush);
            else passed++;
            advance();
        end
        rst = 0;
        set_idle();
    endtask

    task automatic test_raw(int tuse, int want_stalls);
        logic [NREG+1:0] e;
        int nst;
        do_reset();
        set_iss(1, 1, 8, 3, 0, 0, 0, 0);
        e = mexp();
        @(negedge clk);
        checks++;
        if ({stall, issue, busy_vec} !== e)
            $display("[TB] FAIL raw_issue: got %b/%b/%h want %b/%b/%h",
                     stall, issue, busy_vec, e[NREG+1], e[NREG], e[NREG-1:0]);
        else passed++;
        advance();
        set_iss(1, 0, 0, 0, 8, tuse, 0, 0);
        nst = 0;
        for (int k = 0; k < 10; k++) begin
            e = mexp();
            @(negedge clk);
            checks++;
            if ({stall, issue, busy_vec} !== e)
                $display("[TB] FAIL raw_tuse%0d c%0d: got %b/%b/%h want %b/%b/%h", tuse, k,
                         stall, issue, busy_vec, e[NREG+1], e[NREG], e[NREG-1:0]);
            else passed++;
            if (issue === 1'b1) begin
                advance();
                break;
            end
            nst++;
            advance();
        end
        checks++;
        if (nst != want_stalls)
            $display("[TB] FAIL raw_stall_count tuse=%0d: got %0d want %0d", tuse, nst, want_stalls);
        else passed++;
        set_idle();
    endtask

    task automatic test_bypass();
        logic [NREG+1:0] e;
        do_reset();
        set_iss(1, 1, 9, 3, 0, 0, 0, 0);
        advance();
        set_idle();
        advance();
        set_iss(1, 0, 0, 0, 9, 0, 0, 0);
        wb_we = 1; wb_addr = 9;
        e = mexp();
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || {stall, issue, busy_vec} !== e)
            $display("[TB] FAIL bypass_read: got stall=%b issue=%b busy=%h want stall=0 issue=1 busy=%h",
                     stall, issue, busy_vec, e[NREG-1:0]);
        else passed++;
        advance();
        set_idle();
        @(negedge clk);
        checks++;
        if (busy_vec[9] !== 1'b0)
            $display("[TB] FAIL bypass_busy9: got %b want 0", busy_vec[9]);
        else passed++;
        advance();
    endtask

    task automatic test_waw();
        logic [NREG+1:0] e;
        do_reset();
        for (int k = 0; k < 14; k++) begin
            set_idle();
            case (k)
                0, 1, 2:  set_iss(1, 1, 5, $urandom_range(1, 7), 0, 0, 0, 0);
                3, 4, 5:  set_iss(1, 1, 5, 2, 0, 0, 0, 0);
                6: begin set_iss(1, 1, 5, 2, 0, 0, 0, 0); wb_we = 1; wb_addr = 5; end
                7:        set_iss(1, 1, 5, 2, 0, 0, 0, 0);
                8: begin wb_we = 1; wb_addr = 5; end
                9: begin set_iss(1, 1, 5, 6, 0, 0, 0, 0); wb_we = 1; wb_addr = 5; end
                10, 11:   set_iss(1, 0, 0, 0, 5, 5, 0, 0);
                default: begin wb_we = 1; wb_addr = 5; end
            endcase
            e = mexp();
            @(negedge clk);
            checks++;
            if ({stall, issue, busy_vec} !== e)
                $display("[TB] FAIL waw c%0d: got %b/%b/%h want %b/%b/%h", k,
                         stall, issue, busy_vec, e[NREG+1], e[NREG], e[NREG-1:0]);
            else passed++;
            advance();
        end
        set_idle();
    endtask

    task automatic test_zero_flush();
        logic [NREG+1:0] e;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            set_idle();
            case (k)
                0: set_iss(1, 1, 3, 7, 0, 0, 0, 0);
                1: set_iss(1, 1, 0, 7, 0, 0, 0, 0);
                2: begin set_iss(1, 1, 3, 4, 3, 0, 3, 0); flush = 1; end
                3: begin wb_we = 1; wb_addr = 3; end
                4: set_iss(1, 0, 0, 0, 3, 0, 0, 0);
                default: begin set_iss(1, 1, 0, 0, 0, 0, 0, 0); wb_we = 1; wb_addr = 0; end
            endcase
            e = mexp();
            @(negedge clk);
            checks++;
            if ({stall, issue, busy_vec} !== e)
                $display("[TB] FAIL zero_flush c%0d: got %b/%b/%h want %b/%b/%h", k,
                         stall, issue, busy_vec, e[NREG+1], e[NREG], e[NREG-1:0]);
            else passed++;
            advance();
        end
        set_idle();
    endtask

    task automatic test_underflow();
        logic [NREG+1:0] e;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_idle();
            wb_we = (k < 3); wb_addr = 12;
            if (k == 2) set_iss(1, 1, 12, 1, 0, 0, 0, 0);
            e = mexp();
            @(negedge clk);
            checks++;
            if ({stall, issue, busy_vec} !== e)
                $display("[TB] FAIL underflow c%0d: got %b/%b/%h want %b/%b/%h", k,
                         stall, issue, busy_vec, e[NREG+1], e[NREG], e[NREG-1:0]);
            else passed++;
            advance();
        end
        set_idle();
    endtask

    task automatic test_random(int n);
        logic [NREG+1:0] e;
        for (int k = 0; k < n; k++) begin
            set_iss(($urandom_range(0, 9) < 8) ? 1 : 0, ($urandom_range(0, 9) < 6) ? 1 : 0,
                    $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 7));
            flush = ($urandom_range(0, 9) == 0);
            wb_we = ($urandom_range(0, 9) < 4);
            wb_addr = AW'($urandom_range(0, 7));
            e = mexp();
            @(negedge clk);
            checks++;
            if ({stall, issue, busy_vec} !== e)
                $display("[TB] FAIL random c%0d: got %b/%b/%h want %b/%b/%h", k,
                         stall, issue, busy_vec, e[NREG+1], e[NREG], e[NREG-1:0]);
            else passed++;
            advance();
        end
        set_idle();
    endtask

    task automatic test_midrun_reset();
        for (int k = 0; k < 6; k++) begin
            set_iss(1, 1, 6, 7, 0, 0, 0, 0);
            advance();
        end
        set_iss(1, 1, 6, 2, 6, 0, 6, 0);
        #2;
        rst = 1;
        model_clear();
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if ({stall, issue, busy_vec} !== {1'b0, 1'b1, {NREG{1'b0}}})
                $display("[TB] FAIL midrun_reset c%0d: got stall=%b issue=%b busy=%h want stall=0 issue=1 busy=0",
                         k, stall, issue, busy_vec);
            else passed++;
            advance();
        end
        rst = 0;
        set_idle();
    endtask

    initial begin
        set_idle();
        rst = 1;
        model_clear();
        @(posedge clk);
        #1;
        test_reset();
        test_raw(0, 3);
        test_raw(1, 2);
        test_bypass();
        test_waw();
        test_zero_flush();
        test_underflow();
        do_reset();
        test_random(400);
        test_midrun_reset();
        test_random(200);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
